// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes, FSM states,
// and the iteration-counter width helper.
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // CNT_WIDTH for a given operand width: wide enough to hold DATA_WIDTH itself.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: add-shift for multiply,
// trial-subtract-shift (restoring) for divide, selected by is_div.
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] shreg,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic [DATA_WIDTH-1:0] acc_next,
    output logic [DATA_WIDTH-1:0] shreg_next
);

    logic [DATA_WIDTH-1:0] addend;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] diff;

    // NOTE: every output gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        acc_next   = '0;
        shreg_next = '0;
        addend     = shreg[0] ? operand : {DATA_WIDTH{1'b0}};
        sum        = {1'b0, acc} + {1'b0, addend};
        shifted    = {acc, shreg[DATA_WIDTH-1]};
        // The true difference is below 2^DATA_WIDTH whenever it is used, so W bits suffice.
        diff       = shifted[DATA_WIDTH-1:0] - operand;

        if (is_div) begin
            if (shifted >= {1'b0, operand}) begin
                acc_next   = diff;
                shreg_next = {shreg[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_next   = shifted[DATA_WIDTH-1:0];
                shreg_next = {shreg[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next   = sum[DATA_WIDTH:1];
            shreg_next = {sum[0], shreg[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MF/MT access.
// Optional divide-by-zero flag output enabled by defining MULDIV_DIV0_FLAG_EN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MODE_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [MODE_WIDTH-1:0] i_op,
    input  logic [DATA_WIDTH-1:0] i_A,
    input  logic [DATA_WIDTH-1:0] i_B,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_stall
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    output logic                  o_div_zero
`endif
);

    localparam int                   CNT_WIDTH = cnt_width(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] hi, lo, acc, shreg, operand;
    logic [DATA_WIDTH-1:0] acc_next, shreg_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  run_div, neg_main, neg_rem, b_zero;

    logic is_mfhi, is_mthi, is_mflo, is_mtlo, is_mult, is_multu, is_div, is_divu;
    logic is_md, op_signed, accept, start_md, last;
    logic [DATA_WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [2*DATA_WIDTH-1:0] product, prod_fix;

    assign is_mfhi  = (i_op == MODE_WIDTH'(FUNCT_MFHI));
    assign is_mthi  = (i_op == MODE_WIDTH'(FUNCT_MTHI));
    assign is_mflo  = (i_op == MODE_WIDTH'(FUNCT_MFLO));
    assign is_mtlo  = (i_op == MODE_WIDTH'(FUNCT_MTLO));
    assign is_mult  = (i_op == MODE_WIDTH'(FUNCT_MULT));
    assign is_multu = (i_op == MODE_WIDTH'(FUNCT_MULTU));
    assign is_div   = (i_op == MODE_WIDTH'(FUNCT_DIV));
    assign is_divu  = (i_op == MODE_WIDTH'(FUNCT_DIVU));

    assign is_md     = is_mult | is_multu | is_div | is_divu;
    assign op_signed = is_mult | is_div;
    assign accept    = i_start & ~o_busy;
    assign start_md  = accept & is_md;
    assign last      = (state == RUN) && (cnt == LAST_STEP);

    assign a_mag = (op_signed & i_A[DATA_WIDTH-1]) ? -i_A : i_A;
    assign b_mag = (op_signed & i_B[DATA_WIDTH-1]) ? -i_B : i_B;

    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .is_div     (run_div),
        .acc        (acc),
        .shreg      (shreg),
        .operand    (operand),
        .acc_next   (acc_next),
        .shreg_next (shreg_next)
    );

    // Sign fix-up applied to the final iteration's outputs as they are written to HI/LO.
    assign product  = {acc_next, shreg_next};
    assign prod_fix = neg_main ? -product : product;
    assign quo_fix  = b_zero ? {DATA_WIDTH{1'b1}} : (neg_main ? -shreg_next : shreg_next);
    assign rem_fix  = neg_rem ? -acc_next : acc_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state)
            IDLE: if (start_md) state_next = RUN;
            RUN: begin
                o_busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = start_md ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: HI/LO are architectural and reset to zero; the iteration registers are reset too
    // so an aborted run leaves nothing stale behind.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            shreg    <= '0;
            operand  <= '0;
            cnt      <= '0;
            run_div  <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
        end else if (start_md) begin
            run_div  <= is_div | is_divu;
            acc      <= '0;
            shreg    <= (is_div | is_divu) ? a_mag : b_mag;
            operand  <= (is_div | is_divu) ? b_mag : a_mag;
            cnt      <= '0;
            neg_main <= op_signed & (i_A[DATA_WIDTH-1] ^ i_B[DATA_WIDTH-1]);
            neg_rem  <= op_signed & i_A[DATA_WIDTH-1];
            b_zero   <= (is_div | is_divu) && (i_B == '0);
        end else if (o_busy) begin
            acc   <= acc_next;
            shreg <= shreg_next;
            cnt   <= cnt + CNT_WIDTH'(1);
            if (last) begin
                if (run_div) {hi, lo} <= {rem_fix, quo_fix};
                else         {hi, lo} <= prod_fix;
            end
        end else if (accept) begin
            if (is_mthi) hi <= i_A;
            if (is_mtlo) lo <= i_A;
        end
    end

`ifdef MULDIV_DIV0_FLAG_EN
    logic div_zero_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)       div_zero_q <= 1'b0;
        else if (start_md) div_zero_q <= 1'b0;
        else if (last)     div_zero_q <= b_zero;
    end

    assign o_div_zero = div_zero_q;
`endif

    always_comb begin
        o_result = '0;
        if (is_mfhi)      o_result = hi;
        else if (is_mflo) o_result = lo;
    end

    assign o_hi    = hi;
    assign o_lo    = lo;
    assign o_stall = i_start & o_busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at DATA_WIDTH=8: spec vector table, randomized
// operations against an integer-arithmetic model, and hand-written corner sequences.
module tb_muldiv_unit;

    localparam int W = 8;

    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] result, hi, lo;
    logic         busy, done, stall;
`ifdef MULDIV_DIV0_FLAG_EN
    logic         div_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(W), .MODE_WIDTH(6)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_start  (start),
        .i_op     (op),
        .i_A      (a),
        .i_B      (b),
        .o_result (result),
        .o_hi     (hi),
        .o_lo     (lo),
        .o_busy   (busy),
        .o_done   (done),
        .o_stall  (stall)
`ifdef MULDIV_DIV0_FLAG_EN
        ,
        .o_div_zero (div_zero)
`endif
    );

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] hi;
        logic [7:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definition, returns {HI, LO}.
    function automatic logic [15:0] model(input logic [5:0] f, input logic [7:0] x, input logic [7:0] y);
        int sx, sy, ux, uy, q, r;
        sx = $signed(x);
        sy = $signed(y);
        ux = int'(x);
        uy = int'(y);
        case (f)
            OP_MULT:  return 16'(sx * sy);
            OP_MULTU: return 16'(ux * uy);
            OP_DIV: begin
                if (y == 8'h00) return {x, 8'hFF};
                q = sx / sy;
                r = sx % sy;
                return {8'(r), 8'(q)};
            end
            OP_DIVU: begin
                if (y == 8'h00) return {x, 8'hFF};
                q = ux / uy;
                r = ux % uy;
                return {8'(r), 8'(q)};
            end
            default: return 16'h0000;
        endcase
    endfunction

    // Presents a start for one cycle; returns at #1 after the accepting edge with random operands on the bus.
    task automatic launch(input logic [5:0] f, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = f;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
    endtask

    // Samples once per cycle (#1 after each edge) until o_done, bounded at 20 cycles.
    task automatic wait_done(output logic [7:0] got_hi, output logic [7:0] got_lo,
                             output int busy_cycles, output bit got_done);
        busy_cycles = 0;
        got_done    = 1'b0;
        got_hi      = '0;
        got_lo      = '0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                got_done = 1'b1;
                got_hi   = hi;
                got_lo   = lo;
                break;
            end
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  got_hi, got_lo;
        logic [15:0] exp;
        logic [5:0]  md_ops[4];
        int          nbusy;
        bit          got_done;
        bit          saw_done;

        vecs[0] = '{"mult_neg3x5",   OP_MULT,  8'hFD, 8'h05, 8'hFF, 8'hF1};
        vecs[1] = '{"divu_200_7",    OP_DIVU,  8'hC8, 8'h07, 8'h04, 8'h1C};
        vecs[2] = '{"div_neg7_2",    OP_DIV,   8'hF9, 8'h02, 8'hFF, 8'hFD};
        vecs[3] = '{"divu_13_0",     OP_DIVU,  8'h0D, 8'h00, 8'h0D, 8'hFF};
        vecs[4] = '{"div_min_neg1",  OP_DIV,   8'h80, 8'hFF, 8'h00, 8'h80};
        vecs[5] = '{"multu_ff_ff",   OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01};
        vecs[6] = '{"mult_min_min",  OP_MULT,  8'h80, 8'h80, 8'h40, 8'h00};
        vecs[7] = '{"div_neg13_0",   OP_DIV,   8'hF3, 8'h00, 8'hF3, 8'hFF};
        vecs[8] = '{"div_7_neg2",    OP_DIV,   8'h07, 8'hFE, 8'h01, 8'hFD};
        vecs[9] = '{"mult_0x7f_neg1",OP_MULT,  8'h7F, 8'hFF, 8'hFF, 8'h81};

        md_ops[0] = OP_MULT;
        md_ops[1] = OP_MULTU;
        md_ops[2] = OP_DIV;
        md_ops[3] = OP_DIVU;

        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hi", hi, 8'h00);
        check("reset_lo", lo, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(got_hi, got_lo, nbusy, got_done);
            check({vecs[i].name, "_done"}, got_done, 1'b1);
            check({vecs[i].name, "_busy_cycles"}, nbusy, 8);
            check({vecs[i].name, "_hi"}, got_hi, vecs[i].hi);
            check({vecs[i].name, "_lo"}, got_lo, vecs[i].lo);
`ifdef MULDIV_DIV0_FLAG_EN
            check({vecs[i].name, "_div_zero"}, div_zero,
                  ((vecs[i].op == OP_DIV || vecs[i].op == OP_DIVU) && vecs[i].b == 8'h00));
`endif
        end

        for (int i = 0; i < 40; i++) begin
            logic [5:0] f;
            logic [7:0] x, y;
            f = md_ops[$urandom_range(0, 3)];
            x = 8'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            exp = model(f, x, y);
            launch(f, x, y);
            wait_done(got_hi, got_lo, nbusy, got_done);
            check($sformatf("rand%0d_op%0h_%0h_%0h_done", i, f, x, y), got_done, 1'b1);
            check($sformatf("rand%0d_op%0h_%0h_%0h_hilo", i, f, x, y), {got_hi, got_lo}, exp);
        end

        launch(OP_MTHI, 8'h5A, 8'h00);
        check("mthi_hi", hi, 8'h5A);
        check("mthi_busy", busy, 1'b0);
        launch(OP_MTLO, 8'hA5, 8'h00);
        check("mtlo_lo", lo, 8'hA5);
        check("mtlo_hi_kept", hi, 8'h5A);
        op = OP_MFHI;
        #1;
        check("mfhi_result", result, 8'h5A);
        op = OP_MFLO;
        #1;
        check("mflo_result", result, 8'hA5);
        op = OP_MULT;
        #1;
        check("other_result_zero", result, 8'h00);
        launch(6'b111111, 8'h33, 8'h44);
        check("unknown_hi", hi, 8'h5A);
        check("unknown_lo", lo, 8'hA5);
        check("unknown_busy", busy, 1'b0);

        launch(OP_MULT, 8'h03, 8'h05);
        for (int k = 0; k < 4; k++) begin
            start = 1'b1;
            op    = (k < 2) ? OP_MFLO : OP_MTLO;
            a     = 8'h33;
            #1;
            check($sformatf("stall_cycle%0d", k), stall, 1'b1);
            check($sformatf("stall_lo_kept%0d", k), lo, 8'hA5);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        #1;
        check("stall_released", stall, 1'b0);
        wait_done(got_hi, got_lo, nbusy, got_done);
        check("stall_mult_done", got_done, 1'b1);
        check("stall_mult_hilo", {got_hi, got_lo}, 16'h000F);

        launch(OP_MULTU, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 8'h00);
        check("abort_lo", lo, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 1'b0);

        launch(OP_DIVU, 8'hC8, 8'h07);
        wait_done(got_hi, got_lo, nbusy, got_done);
        check("b2b_first_done", got_done, 1'b1);
        check("b2b_first_hilo", {got_hi, got_lo}, 16'h041C);
        start = 1'b1;
        op    = OP_MULT;
        a     = 8'hFD;
        b     = 8'h05;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_no_gap_busy", busy, 1'b1);
        wait_done(got_hi, got_lo, nbusy, got_done);
        check("b2b_second_done", got_done, 1'b1);
        check("b2b_second_busy_cycles", nbusy, 8);
        check("b2b_second_hilo", {got_hi, got_lo}, 16'hFFF1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
